audio_dac_tx: RTL



---
 rtl/audio_dac_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/audio_dac_tx.sv
// Left-justified serial audio transmitter: stereo 24-bit frames from a 2-deep FIFO,
// shifted MSB-first on AUD_DACDAT in 32-BCLK slots, codec is BCLK/LRCK master.
//
//   state      | meaning
//   WAIT_ALIGN | output held at 0, waiting for the first 0->1 LRC edge
//   RUN        | aligned to the LR clock, serialising left/right slots
module audio_dac_tx (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        AUD_BCLK,
    input  logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    input  logic [23:0] L_IN,
    input  logic [23:0] R_IN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic        UNDERRUN,
    output logic [15:0] UNDERRUN_CNT
);

    typedef enum logic {
        WAIT_ALIGN = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        bclk_s1;
    logic        bclk_s2;
    logic        bclk_s3;
    logic        lrc_s1;
    logic        lrc_s2;
    logic        lrc_prev;

    logic        bclk_fall;
    logic        left_start;
    logic        right_start;
    logic        do_left;
    logic        do_right;
    logic        do_shift;

    logic [47:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [47:0] head;
    logic        push;
    logic        pop;
    logic        underrun_evt;

    logic [23:0] shift_reg;
    logic [23:0] r_hold;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_inc;

    // Synchronisers keep sampling during reset so lrc_prev can track the true LRC level.
    always_ff @(posedge MCLK) begin
        bclk_s1 <= AUD_BCLK;
        bclk_s2 <= bclk_s1;
        bclk_s3 <= bclk_s2;
        lrc_s1  <= AUD_DACLRCK;
        lrc_s2  <= lrc_s1;
    end

    assign bclk_fall   = bclk_s3 & ~bclk_s2;
    assign left_start  = bclk_fall &  lrc_s2 & ~lrc_prev;
    assign right_start = bclk_fall & ~lrc_s2 &  lrc_prev;

    always_comb begin
        state_next = state;
        do_left    = 1'b0;
        do_right   = 1'b0;
        do_shift   = 1'b0;
        case (state)
            WAIT_ALIGN: begin
                if (left_start) begin
                    state_next = RUN;
                    do_left    = 1'b1;
                end
            end
            RUN: begin
                do_left  = left_start;
                do_right = right_start;
                do_shift = bclk_fall & ~left_start & ~right_start;
            end
            default: state_next = WAIT_ALIGN;
        endcase
    end

    assign IN_READY     = ~reset & (count < 2'd2);
    assign push         = IN_VALID & IN_READY;
    assign head         = fifo_mem[rd_ptr];
    assign pop          = do_left & (count != 2'd0);
    assign underrun_evt = do_left & (count == 2'd0);
    assign UNDERRUN     = underrun_evt & ~reset;
    assign bit_cnt_inc  = (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;

    always_ff @(posedge MCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {L_IN, R_IN};
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state        <= WAIT_ALIGN;
            lrc_prev     <= lrc_s2;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            shift_reg    <= 24'd0;
            r_hold       <= 24'd0;
            bit_cnt      <= 5'd31;
            AUD_DACDAT   <= 1'b0;
            UNDERRUN_CNT <= 16'd0;
        end else begin
            state <= state_next;
            if (bclk_fall) begin
                lrc_prev <= lrc_s2;
            end

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (do_left) begin
                bit_cnt <= 5'd0;
                if (pop) begin
                    shift_reg  <= head[47:24];
                    r_hold     <= head[23:0];
                    AUD_DACDAT <= head[47];
                end else begin
                    shift_reg  <= 24'd0;
                    r_hold     <= 24'd0;
                    AUD_DACDAT <= 1'b0;
                    if (UNDERRUN_CNT != 16'hFFFF) begin
                        UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
                    end
                end
            end else if (do_right) begin
                bit_cnt    <= 5'd0;
                shift_reg  <= r_hold;
                AUD_DACDAT <= r_hold[23];
            end else if (do_shift) begin
                // Slots longer than 32 BCLK pin bit_cnt at 31, so the line stays low.
                bit_cnt <= bit_cnt_inc;
                if (bit_cnt_inc <= 5'd23) begin
                    AUD_DACDAT <= shift_reg[5'd23 - bit_cnt_inc];
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end else if (state != RUN) begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

endmodule
